mem_port_arbiter: RTL and testbench

- Shares one single-ported memory between two requesters: the instruction-fetch bus and the data bus.
- The instruction-fetch bus is read-only. The data bus can read or write.
- The block sits between the processor's two memory buses and the memory model.
- It grants one requester at a time, sequences a fixed-latency access and returns data to that requester.
- It drives a per-requester miss (stall) signal until the access completes.

---
 rtl/mem_port_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency single-ported memory between an
// instruction-fetch bus (read-only) and a data bus (read/write).
// Default arbitration gives the data bus priority; define MEM_ARB_RR_EN to
// switch to round-robin arbitration when both requesters are pending.
module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [DATA_WIDTH-1:0] i_data,
    output logic                  i_miss,
    input  logic                  d_en,
    input  logic                  d_rw,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_miss,
    output logic                  m_en,
    output logic                  m_rw,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [DATA_WIDTH-1:0] m_wdata,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    output logic                  busy
);

    localparam int unsigned CNT_WIDTH = 4;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic [1:0] {GNT_NONE, GNT_I, GNT_D} grant_t;

    state_t                state, state_n;
    grant_t                grant, grant_n;
    logic [CNT_WIDTH-1:0]  cnt, cnt_n;
    logic                  m_en_n, m_rw_n, busy_n;
    logic [ADDR_WIDTH-1:0] m_addr_n;
    logic [DATA_WIDTH-1:0] m_wdata_n, i_data_n, d_rdata_n;
    logic                  pick_d;
`ifdef MEM_ARB_RR_EN
    grant_t                last_grant, last_grant_n;
`endif

    // Stall each requester until its own DONE cycle; idle requesters never stall.
    assign i_miss = i_req & ~((state == DONE) & (grant == GNT_I));
    assign d_miss = d_en  & ~((state == DONE) & (grant == GNT_D));

    // Arbitration: decide whether the data bus wins a grant taken in IDLE.
    always_comb begin
        pick_d = d_en;
`ifdef MEM_ARB_RR_EN
        if (d_en && i_req) begin
            pick_d = (last_grant == GNT_I);
        end
`endif
    end

    // Next-state and next-output logic; memory controls come from the values latched at grant.
    always_comb begin
        state_n   = state;
        grant_n   = grant;
        cnt_n     = cnt;
        m_en_n    = m_en;
        m_rw_n    = m_rw;
        m_addr_n  = m_addr;
        m_wdata_n = m_wdata;
        i_data_n  = i_data;
        d_rdata_n = d_rdata;
`ifdef MEM_ARB_RR_EN
        last_grant_n = last_grant;
`endif
        unique case (state)
            IDLE: begin
                if (d_en || i_req) begin
                    state_n = BUSY;
                    cnt_n   = '0;
                    m_en_n  = 1'b1;
                    if (pick_d) begin
                        grant_n   = GNT_D;
                        m_rw_n    = d_rw;
                        m_addr_n  = d_addr;
                        m_wdata_n = d_wdata;
                    end else begin
                        grant_n   = GNT_I;
                        m_rw_n    = 1'b0;
                        m_addr_n  = i_addr;
                        m_wdata_n = '0;
                    end
`ifdef MEM_ARB_RR_EN
                    last_grant_n = pick_d ? GNT_D : GNT_I;
`endif
                end
            end
            BUSY: begin
                cnt_n = cnt + CNT_WIDTH'(1);
                if (cnt == CNT_LAST) begin
                    state_n = DONE;
                    m_en_n  = 1'b0;
                    // Reads land in the granted requester's register; writes leave both untouched.
                    if (!m_rw) begin
                        if (grant == GNT_D) begin
                            d_rdata_n = m_rdata;
                        end else begin
                            i_data_n = m_rdata;
                        end
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
                grant_n = GNT_NONE;
            end
            default: begin
                state_n = IDLE;
                grant_n = GNT_NONE;
                m_en_n  = 1'b0;
            end
        endcase
        busy_n = (state_n != IDLE);
    end

    // State and output registers; reset aborts any access in flight.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state   <= IDLE;
            grant   <= GNT_NONE;
            cnt     <= '0;
            m_en    <= 1'b0;
            m_rw    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            i_data  <= '0;
            d_rdata <= '0;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            grant   <= grant_n;
            cnt     <= cnt_n;
            m_en    <= m_en_n;
            m_rw    <= m_rw_n;
            m_addr  <= m_addr_n;
            m_wdata <= m_wdata_n;
            i_data  <= i_data_n;
            d_rdata <= d_rdata_n;
            busy    <= busy_n;
        end
    end

`ifdef MEM_ARB_RR_EN
    // Remember who was served last so ties alternate.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            last_grant <= GNT_I;
        end else begin
            last_grant <= last_grant_n;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter (WAIT_CYCLES=2, default arbitration).
module tb_mem_port_arbiter;

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned WAIT = 2;

    logic          Clk, Rst;
    logic          i_req, i_miss, d_en, d_rw, d_miss;
    logic          m_en, m_rw, busy;
    logic [AW-1:0] i_addr, d_addr, m_addr;
    logic [DW-1:0] i_data, d_wdata, d_rdata, m_wdata, m_rdata;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t iq[$];
    exp_t dq[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    bit [31:0] wmem   [64];
    bit        wvalid [64];

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(WAIT)) dut (
        .Clk(Clk), .Rst(Rst),
        .i_req(i_req), .i_addr(i_addr), .i_data(i_data), .i_miss(i_miss),
        .d_en(d_en), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_miss(d_miss),
        .m_en(m_en), .m_rw(m_rw), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .busy(busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    // Preloaded read contents for the addresses the vectors use.
    function automatic logic [31:0] preload(input logic [AW-1:0] a);
        case (a)
            32'h10:  return 32'hDEADBEEF;
            32'h14:  return 32'h55667788;
            32'h18:  return 32'h0BADC0DE;
            32'h20:  return 32'hCAFEF00D;
            32'h24:  return 32'h11223344;
            default: return 32'h0;
        endcase
    endfunction

    // Memory model: combinational read, write on the clock edge while enabled.
    assign m_rdata = wvalid[m_addr[7:2]] ? wmem[m_addr[7:2]] : preload(m_addr);

    always @(posedge Clk) begin
        if (m_en && m_rw) begin
            wmem[m_addr[7:2]]   <= m_wdata;
            wvalid[m_addr[7:2]] <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every completed transfer pops the matching expectation.
    always @(negedge Clk) begin
        if (!Rst) begin
            if (i_req && !i_miss) begin
                if (iq.size() == 0) begin
                    chk("i_unexpected_done", 64'(cyc), 64'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = iq.pop_front();
                    chk("i_data", 64'(i_data), 64'(e.data));
                    chk("i_done_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
            if (d_en && !d_miss) begin
                if (dq.size() == 0) begin
                    chk("d_unexpected_done", 64'(cyc), 64'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = dq.pop_front();
                    chk("d_rdata", 64'(d_rdata), 64'(e.data));
                    chk("d_done_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    // One uncontended access: t0 request, t1..tWAIT busy, done, then back to idle.
    task automatic single(input bit is_d, input bit rw, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp);
        int c0;
        if (is_d) begin
            d_en = 1'b1; d_rw = rw; d_addr = addr; d_wdata = wdata;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        c0 = cyc;
        if (is_d) dq.push_back('{exp, c0 + WAIT + 1});
        else      iq.push_back('{exp, c0 + WAIT + 1});
        #1;
        chk("miss_t0", 64'(is_d ? d_miss : i_miss), 64'd1);
        for (int k = 1; k <= WAIT; k++) begin
            next_cycle();
            chk("m_en_busy", 64'(m_en), 64'd1);
            chk("m_rw", 64'(m_rw), 64'(rw));
            chk("m_addr", 64'(m_addr), 64'(addr));
            if (rw) chk("m_wdata", 64'(m_wdata), 64'(wdata));
            chk("miss_busy", 64'(is_d ? d_miss : i_miss), 64'd1);
            chk("busy_busy", 64'(busy), 64'd1);
        end
        next_cycle();
        chk("m_en_done", 64'(m_en), 64'd0);
        chk("busy_done", 64'(busy), 64'd1);
        next_cycle();
        i_req = 1'b0;
        d_en  = 1'b0;
        chk("busy_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        int c0;
        Rst = 1'b1;
        i_req = 1'b0; i_addr = '0;
        d_en = 1'b0; d_rw = 1'b0; d_addr = '0; d_wdata = '0;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_m_en", 64'(m_en), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_m_addr", 64'(m_addr), 64'd0);
        chk("rst_i_data", 64'(i_data), 64'd0);
        chk("rst_d_rdata", 64'(d_rdata), 64'd0);
        chk("rst_i_miss", 64'(i_miss), 64'd0);
        chk("rst_d_miss", 64'(d_miss), 64'd0);
        Rst = 1'b0;
        next_cycle();

        // Single fetch, data read, then data write (d_rdata must keep the read value).
        single(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF);
        single(1'b1, 1'b0, 32'h20, 32'h0, 32'hCAFEF00D);
        single(1'b1, 1'b1, 32'h40, 32'h12345678, 32'hCAFEF00D);
        chk("mem_write_40", 64'(wmem[16]), 64'h12345678);
        chk("d_rdata_hold", 64'(d_rdata), 64'hCAFEF00D);
        chk("i_data_hold", 64'(i_data), 64'hDEADBEEF);

        // Contention: D first (done t3), then I (granted t4, done t7).
        d_en = 1'b1; d_rw = 1'b0; d_addr = 32'h24;
        i_req = 1'b1; i_addr = 32'h14;
        c0 = cyc;
        dq.push_back('{32'h11223344, c0 + 3});
        iq.push_back('{32'h55667788, c0 + 7});
        for (int k = 1; k <= 3; k++) begin
            next_cycle();
            if (k <= 2) chk("cont_m_addr_d", 64'(m_addr), 64'h24);
            chk("cont_i_miss", 64'(i_miss), 64'd1);
        end
        next_cycle();
        d_en = 1'b0;
        #1;
        chk("cont_i_miss_t4", 64'(i_miss), 64'd1);
        for (int k = 5; k <= 6; k++) begin
            next_cycle();
            chk("cont_m_addr_i", 64'(m_addr), 64'h14);
            chk("cont_i_miss", 64'(i_miss), 64'd1);
        end
        next_cycle();
        next_cycle();
        i_req = 1'b0;
        chk("cont_busy_idle", 64'(busy), 64'd0);

        // Abandoned write: request and inputs change after the grant; access completes as latched.
        d_en = 1'b1; d_rw = 1'b1; d_addr = 32'h44; d_wdata = 32'hA5A5A5A5;
        next_cycle();
        d_en = 1'b0; d_addr = 32'h99; d_wdata = 32'h0;
        #1;
        for (int k = 1; k <= 2; k++) begin
            if (k == 2) next_cycle();
            chk("ab_m_en", 64'(m_en), 64'd1);
            chk("ab_m_rw", 64'(m_rw), 64'd1);
            chk("ab_m_addr", 64'(m_addr), 64'h44);
            chk("ab_m_wdata", 64'(m_wdata), 64'hA5A5A5A5);
            chk("ab_d_miss", 64'(d_miss), 64'd0);
            chk("ab_i_miss", 64'(i_miss), 64'd0);
        end
        next_cycle();
        chk("ab_done_m_en", 64'(m_en), 64'd0);
        chk("ab_done_d_miss", 64'(d_miss), 64'd0);
        next_cycle();
        chk("ab_idle_busy", 64'(busy), 64'd0);
        chk("ab_mem_44", 64'(wmem[17]), 64'hA5A5A5A5);

        // Reset during a fetch's BUSY phase, then a held request restarts cleanly.
        i_req = 1'b1; i_addr = 32'h18;
        next_cycle();
        chk("rb_m_en", 64'(m_en), 64'd1);
        Rst = 1'b1;
        #1;
        chk("rb_rst_m_en", 64'(m_en), 64'd0);
        chk("rb_rst_busy", 64'(busy), 64'd0);
        chk("rb_rst_i_data", 64'(i_data), 64'd0);
        chk("rb_rst_d_rdata", 64'(d_rdata), 64'd0);
        chk("rb_rst_m_addr", 64'(m_addr), 64'd0);
        next_cycle();
        next_cycle();
        Rst = 1'b0;
        c0 = cyc;
        iq.push_back('{32'h0BADC0DE, c0 + 3});
        for (int k = 1; k <= 2; k++) begin
            next_cycle();
            chk("rb_m_en_busy", 64'(m_en), 64'd1);
            chk("rb_m_addr", 64'(m_addr), 64'h18);
        end
        next_cycle();
        next_cycle();
        i_req = 1'b0;
        chk("rb_busy_idle", 64'(busy), 64'd0);

        // Idle: nothing moves for 10 cycles.
        for (int k = 0; k < 10; k++) begin
            next_cycle();
            chk("idle_m_en", 64'(m_en), 64'd0);
            chk("idle_busy", 64'(busy), 64'd0);
            chk("idle_i_miss", 64'(i_miss), 64'd0);
            chk("idle_d_miss", 64'(d_miss), 64'd0);
        end

        chk("iq_drained", 64'(iq.size()), 64'd0);
        chk("dq_drained", 64'(dq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
